// File: rtl/empaquetador_2a8.sv
// Packs four 2-bit symbols MSB-first into a byte and queues it in a 4-deep show-ahead FIFO.
// Word visible one edge after its 4th symbol; the 4th symbol stalls (ready_in=0) only while the FIFO is full.
module empaquetador_2a8 #(
  parameter int SYM_W         = 2,
  parameter int SYMS_PER_WORD = 4,
  parameter int WORD_W        = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_W         = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              valid_in,
  input  logic [SYM_W-1:0]  data_in,
  input  logic              flush,
  output logic              ready_in,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LAST_SYM = SYMS_PER_WORD - 1;

  typedef enum logic [1:0] {ACC0, ACC1, ACC2, ACC3} acc_state_e;

  acc_state_e        state_q, state_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic              last_sym;
  logic              fifo_full;
  logic              accept;
  logic              push;
  logic              pop;
  logic [WORD_W-1:0] word;

  assign last_sym  = (state_q == acc_state_e'(LAST_SYM[1:0]));
  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  // Deliberately ignores ready_out so no combinational path crosses the block.
  assign ready_in  = !last_sym || !fifo_full;
  assign accept    = valid_in && ready_in && !flush;
  assign push      = accept && last_sym;
  assign pop       = (count_q != '0) && ready_out;
  assign word      = {acc_q[WORD_W-SYM_W-1:0], data_in};

  assign data_out   = mem_q[rd_ptr_q];
  assign valid_out  = (count_q != '0);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (flush) begin
      state_d = ACC0;
      acc_d   = '0;
    end else if (accept) begin
      if (last_sym) begin
        state_d         = ACC0;
        acc_d           = '0;
        mem_d[wr_ptr_q] = word;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        state_d = acc_state_e'(state_q + 2'd1);
        acc_d   = word;
      end
    end else if (valid_in) begin
      overflow_d = 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ACC0;
      acc_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
